// File: rtl/cpu_controller.sv
// Eight-phase fetch/decode/execute sequencer for the 5-bit-address RISC CPU.
// State is a phase counter plus a sticky halted flag; all strobes are a combinational decode.
module cpu_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       wr,
    output logic       data_e,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        PhInstAddr  = 3'd0,
        PhInstFetch = 3'd1,
        PhInstLoad  = 3'd2,
        PhIdle      = 3'd3,
        PhOpAddr    = 3'd4,
        PhOpFetch   = 3'd5,
        PhAluOp     = 3'd6,
        PhStore     = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        OpHlt = 3'd0,
        OpSkz = 3'd1,
        OpAdd = 3'd2,
        OpAnd = 3'd3,
        OpXor = 3'd4,
        OpLda = 3'd5,
        OpSto = 3'd6,
        OpJmp = 3'd7
    } opcode_e;

    phase_e  phase_q, phase_d;
    logic    halted_q, halted_d;
    opcode_e op;
    logic    is_aluop;

    assign op       = opcode_e'(opcode);
    assign is_aluop = (op == OpAdd) || (op == OpAnd) || (op == OpXor) || (op == OpLda);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PhInstAddr;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // HLT in phase 4 freezes the counter at phase 4; only reset leaves the halted state.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (phase_q == PhOpAddr && op == OpHlt) begin
                halted_d = 1'b1;
            end else begin
                phase_d = phase_e'(phase_q + 3'd1);
            end
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            unique case (phase_q)
                PhInstAddr: begin
                    sel = 1'b1;
                end
                PhInstFetch: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PhInstLoad, PhIdle: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PhOpAddr: begin
                    if (op == OpHlt) begin
                        halt = 1'b1;
                    end else begin
                        inc_pc = 1'b1;
                    end
                end
                PhOpFetch: begin
                    rd = is_aluop;
                end
                PhAluOp: begin
                    rd     = is_aluop;
                    inc_pc = (op == OpSkz) && zero;
                    ld_pc  = (op == OpJmp);
                    data_e = (op == OpSto);
                end
                PhStore: begin
                    rd     = is_aluop;
                    ld_ac  = is_aluop;
                    ld_pc  = (op == OpJmp);
                    wr     = (op == OpSto);
                    data_e = (op == OpSto);
                end
                default: ;
            endcase
        end
    end

    assign phase = phase_q;

    // STO never reads, so the memory is never driven and sampled in the same cycle.
    assert property (@(posedge clk) disable iff (!rst_n) !(wr && rd));

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: per-phase strobe table, hand-written reset/halt/SKZ
// sequences, and a randomized run against a rule-based reference model.
module tb_cpu_controller;

    logic       clk;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    logic [2:0] phase;

    int total;
    int bad;

    cpu_controller dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .halt   (halt),
        .inc_pc (inc_pc),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .wr     (wr),
        .data_e (data_e),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e}
    logic [11:0] obs;
    assign obs = {phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};

    typedef struct {
        logic [2:0] op;
        logic       z;
        // One bit per phase (bit p = value during phase p)
        logic [7:0] m_sel, m_rd, m_ld_ir, m_halt, m_inc_pc, m_ld_ac, m_ld_pc, m_wr, m_data_e;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: spec rules stated directly as set membership over phase/opcode.
    function automatic logic [11:0] model(input int ph, input bit hlt, input logic [2:0] op,
                                          input logic z);
        bit alu;
        logic [8:0] v;
        alu = (op >= 3'd2) && (op <= 3'd5);
        if (hlt) return {3'd4, 9'b0_0_0_1_0_0_0_0_0};
        v[8] = (ph < 4);
        v[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        v[6] = (ph == 2 || ph == 3);
        v[5] = (ph == 4 && op == 3'd0);
        v[4] = (ph == 4 && op != 3'd0) || (ph == 6 && op == 3'd1 && z);
        v[3] = (ph == 7 && alu);
        v[2] = (ph >= 6 && op == 3'd7);
        v[1] = (ph == 7 && op == 3'd6);
        v[0] = (ph >= 6 && op == 3'd6);
        return {3'(ph), v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic z, input logic [7:0] rdm,
                                input logic [7:0] incm, input logic [7:0] acm,
                                input logic [7:0] pcm, input logic [7:0] wrm,
                                input logic [7:0] dem);
        vec_t v;
        v.op = op; v.z = z;
        v.m_sel = 8'h0F; v.m_ld_ir = 8'h0C; v.m_halt = 8'h00;
        v.m_rd = rdm; v.m_inc_pc = incm; v.m_ld_ac = acm;
        v.m_ld_pc = pcm; v.m_wr = wrm; v.m_data_e = dem;
        return v;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int ph;
        bit hlt;
        logic [2:0] op;
        logic z;
        logic [11:0] e;

        total = 0;
        bad = 0;
        opcode = 3'd2;
        zero = 1'b0;
        rst_n = 1'b0;

        //        op    z     rd     inc    ac     pc     wr     data_e
        tbl[0] = mk(3'd2, 1'b0, 8'hEE, 8'h10, 8'h80, 8'h00, 8'h00, 8'h00); // ADD
        tbl[1] = mk(3'd3, 1'b1, 8'hEE, 8'h10, 8'h80, 8'h00, 8'h00, 8'h00); // AND
        tbl[2] = mk(3'd4, 1'b0, 8'hEE, 8'h10, 8'h80, 8'h00, 8'h00, 8'h00); // XOR
        tbl[3] = mk(3'd5, 1'b1, 8'hEE, 8'h10, 8'h80, 8'h00, 8'h00, 8'h00); // LDA
        tbl[4] = mk(3'd6, 1'b0, 8'h0E, 8'h10, 8'h00, 8'h00, 8'h80, 8'hC0); // STO
        tbl[5] = mk(3'd7, 1'b1, 8'h0E, 8'h10, 8'h00, 8'hC0, 8'h00, 8'h00); // JMP
        tbl[6] = mk(3'd1, 1'b1, 8'h0E, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00); // SKZ taken
        tbl[7] = mk(3'd1, 1'b0, 8'h0E, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00); // SKZ not taken

        #3;
        chk("reset_state", obs, {3'd0, 9'b1_0000_0000});
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Table: back-to-back instructions, each checked in all 8 phases.
        for (int i = 0; i < 8; i++) begin
            opcode = tbl[i].op;
            zero = tbl[i].z;
            for (int p = 0; p < 8; p++) begin
                if (p > 0) tick();
                e = {3'(p), tbl[i].m_sel[p], tbl[i].m_rd[p], tbl[i].m_ld_ir[p], tbl[i].m_halt[p],
                     tbl[i].m_inc_pc[p], tbl[i].m_ld_ac[p], tbl[i].m_ld_pc[p], tbl[i].m_wr[p],
                     tbl[i].m_data_e[p]};
                chk($sformatf("table%0d_ph%0d", i, p), obs, e);
            end
            tick();
        end

        // Async reset in phase 5, then the phase sequence after release.
        do_reset();
        opcode = 3'd2;
        for (int p = 0; p < 5; p++) tick();
        chk("pre_reset_ph5", obs, model(5, 0, 3'd2, zero));
        rst_n = 1'b0;
        #1;
        chk("async_reset_ph5", obs, {3'd0, 9'b1_0000_0000});
        @(negedge clk);
        chk("reset_held", obs, {3'd0, 9'b1_0000_0000});
        rst_n = 1'b1;
        for (int p = 1; p <= 8; p++) begin
            tick();
            chk($sformatf("release_seq%0d", p), {9'b0, phase}, {9'b0, 3'(p % 8)});
        end

        // SKZ with zero toggling everywhere except a fixed value in phase 6.
        for (int t = 0; t < 2; t++) begin
            do_reset();
            opcode = 3'd1;
            for (int p = 0; p < 8; p++) begin
                if (p > 0) tick();
                zero = (p == 6) ? 1'(t) : 1'($urandom_range(0, 1));
                #1;
                chk($sformatf("skz_z%0d_ph%0d", t, p), obs, model(p, 0, 3'd1, zero));
            end
        end

        // HLT: halt in phase 4, frozen for 20 clocks, cleared only by reset.
        do_reset();
        opcode = 3'd2;
        for (int p = 0; p < 3; p++) tick();
        opcode = 3'd0;
        tick();
        chk("hlt_ph4", obs, {3'd4, 9'b0_0_0_1_0_0_0_0_0});
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            opcode = 3'($urandom_range(0, 7));
            zero = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("halted%0d", c), obs, {3'd4, 9'b0_0_0_1_0_0_0_0_0});
        end
        rst_n = 1'b0;
        #1;
        chk("halt_reset", obs, {3'd0, 9'b1_0000_0000});
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run against the model, with occasional async resets.
        ph = 0;
        hlt = 0;
        for (int c = 0; c < 600; c++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd0 && $urandom_range(0, 3) != 0) op = 3'd2;
            z = 1'($urandom_range(0, 1));
            opcode = op;
            zero = z;
            #1;
            chk($sformatf("rand%0d", c), obs, model(ph, hlt, op, z));
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                #1;
                ph = 0;
                hlt = 0;
                chk($sformatf("rand_rst%0d", c), obs, model(0, 0, op, z));
                @(negedge clk);
                rst_n = 1'b1;
            end
            if (!hlt) begin
                if (ph == 4 && op == 3'd0) hlt = 1;
                else ph = (ph + 1) % 8;
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
